// File: rtl/apb_timer_slave.sv
// APB completer for the 8-bit timer.
// Decodes TDR/TCR/TSR/TCNT, runs a prescaled up/down counter with sticky
// wrap flags, and inserts WAIT_CYCLES wait states before each completion.
module apb_timer_slave #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       irq_ovf,
  output logic       irq_udf
);

  localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYCLES);

  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       en_q, en_d;
  logic       dn_q, dn_d;
  logic [1:0] cks_q, cks_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic [3:0] presc_q, presc_d;
  logic [3:0] wait_q, wait_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic [7:0] prdata_q, prdata_d;

  logic       access;
  logic       setup;
  logic       complete;
  logic       mapped;
  logic       wr_en;
  logic       wr_tdr;
  logic       wr_tcr;
  logic       wr_tsr;
  logic       load;
  logic [3:0] tick_mask;
  logic       tick;
  logic       ovf_set;
  logic       udf_set;
  logic [7:0] rd_val;

  // Bus decode: pready is registered, so it is predicted one cycle early
  // from the phase and the count of access cycles already spent waiting.
  always_comb begin
    access    = psel & penable;
    setup     = psel & ~penable;
    complete  = access & pready_q;
    mapped    = (paddr <= 8'h03);
    wr_en     = complete & pwrite & mapped;
    wr_tdr    = wr_en & (paddr == 8'h00);
    wr_tcr    = wr_en & (paddr == 8'h01);
    wr_tsr    = wr_en & (paddr == 8'h02);
    load      = wr_tcr & pwdata[7];
    wait_d    = wait_q;
    pready_d  = 1'b0;
    if (!psel || complete) begin
      wait_d = 4'd0;
    end else if (access) begin
      wait_d = wait_q + 4'd1;
    end
    if (setup) begin
      pready_d = (WAIT_LAST == 5'd0);
    end else if (access && !pready_q) begin
      pready_d = (({1'b0, wait_q} + 5'd1) == WAIT_LAST);
    end
    pslverr_d = pready_d & ~mapped;
  end

  // Prescaler and counter: a tick fires when the CKS-selected low prescaler
  // bits are all ones; a LOAD overrides any tick in the same cycle.
  always_comb begin
    tick_mask = {cks_q == 2'd3, cks_q[1], cks_q != 2'd0, 1'b1};
    tick      = en_q & ((presc_q & tick_mask) == tick_mask);
    presc_d   = 4'd0;
    tcnt_d    = tcnt_q;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (!load && en_q) begin
      presc_d = presc_q + 4'd1;
    end
    if (load) begin
      tcnt_d = tdr_q;
    end else if (tick) begin
      if (dn_q) begin
        tcnt_d  = tcnt_q - 8'd1;
        udf_set = (tcnt_q == 8'h00);
      end else begin
        tcnt_d  = tcnt_q + 8'd1;
        ovf_set = (tcnt_q == 8'hFF);
      end
    end
  end

  // Register writes and sticky flags; a flag being set beats its own W1C.
  always_comb begin
    tdr_d = wr_tdr ? pwdata : tdr_q;
    en_d  = wr_tcr ? pwdata[4] : en_q;
    dn_d  = wr_tcr ? pwdata[5] : dn_q;
    cks_d = wr_tcr ? pwdata[1:0] : cks_q;
    ovf_d = ovf_set | (ovf_q & ~(wr_tsr & pwdata[0]));
    udf_d = udf_set | (udf_q & ~(wr_tsr & pwdata[1]));
  end

  // Read data is captured from next-state values so that prdata shows the
  // register contents as they stand during the pready cycle.
  always_comb begin
    rd_val = 8'h00;
    case (paddr)
      8'h00:   rd_val = tdr_d;
      8'h01:   rd_val = {2'b00, dn_d, en_d, 2'b00, cks_d};
      8'h02:   rd_val = {6'b000000, udf_d, ovf_d};
      8'h03:   rd_val = tcnt_d;
      default: rd_val = 8'h00;
    endcase
    prdata_d = (pready_d && !pwrite && mapped) ? rd_val : 8'h00;
  end

  // State registers, all cleared asynchronously by preset.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr_q     <= 8'h00;
      tcnt_q    <= 8'h00;
      en_q      <= 1'b0;
      dn_q      <= 1'b0;
      cks_q     <= 2'b00;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      presc_q   <= 4'd0;
      wait_q    <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 8'h00;
    end else begin
      tdr_q     <= tdr_d;
      tcnt_q    <= tcnt_d;
      en_q      <= en_d;
      dn_q      <= dn_d;
      cks_q     <= cks_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      presc_q   <= presc_d;
      wait_q    <= wait_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign irq_ovf = ovf_q;
  assign irq_udf = udf_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: two instances (no wait states and three wait
// states) driven by fixed-timing APB transfers. Expected read responses go
// into a per-instance scoreboard queue; a negedge monitor pops and compares.
module tb_apb_timer_slave;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel [2];
  logic       penable [2];
  logic       pwrite [2];
  logic [7:0] paddr [2];
  logic [7:0] pwdata [2];
  logic [7:0] prdata [2];
  logic       pready [2];
  logic       pslverr [2];
  logic       irq_ovf [2];
  logic       irq_udf [2];

  bit         exp_rdy [2];
  int         wait_of [2];
  int         vectors = 0;
  int         miscompares = 0;
  logic [16:0] sb0 [$];
  logic [16:0] sb1 [$];
  logic [16:0] mon_e;
  int          mon_n;

  int m_tdr [2];
  int m_tcnt [2];
  int m_en [2];
  int m_dn [2];
  int m_cks [2];
  int m_ovf [2];
  int m_udf [2];
  int m_k [2];

  always #5 pclk = ~pclk;

  apb_timer_slave #(.WAIT_CYCLES(W0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .irq_ovf(irq_ovf[0]), .irq_udf(irq_udf[0]));

  apb_timer_slave #(.WAIT_CYCLES(W1)) dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .irq_ovf(irq_ovf[1]), .irq_udf(irq_udf[1]));

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Register view of the timer as the CPU would read it.
  function automatic logic [7:0] model_read(input int i, input logic [7:0] a);
    case (a)
      8'h00:   return 8'(m_tdr[i]);
      8'h01:   return 8'((m_dn[i] << 5) | (m_en[i] << 4) | m_cks[i]);
      8'h02:   return 8'((m_udf[i] << 1) | m_ovf[i]);
      8'h03:   return 8'(m_tcnt[i]);
      default: return 8'h00;
    endcase
  endfunction

  // One clock of timer behaviour: ticks every 2<<CKS cycles of enabled time.
  task automatic model_step(input int i);
    bit         commit, wr, load, tick, ovf_set, udf_set;
    int         period;
    logic [7:0] a, d;
    a       = paddr[i];
    d       = pwdata[i];
    commit  = psel[i] && penable[i] && exp_rdy[i];
    wr      = commit && pwrite[i] && (a <= 8'h03);
    load    = wr && (a == 8'h01) && d[7];
    period  = 2 << m_cks[i];
    tick    = (m_en[i] != 0) && ((m_k[i] % period) == period - 1);
    ovf_set = 0;
    udf_set = 0;
    if (load) m_tcnt[i] = m_tdr[i];
    else if (tick) begin
      if (m_dn[i] == 0) begin
        if (m_tcnt[i] == 255) ovf_set = 1;
        m_tcnt[i] = (m_tcnt[i] + 1) % 256;
      end else begin
        if (m_tcnt[i] == 0) udf_set = 1;
        m_tcnt[i] = (m_tcnt[i] + 255) % 256;
      end
    end
    if (load) m_k[i] = 0;
    else if (m_en[i] != 0) m_k[i] = (m_k[i] + 1) % 16;
    else m_k[i] = 0;
    if (wr && a == 8'h02) begin
      if (d[0]) m_ovf[i] = 0;
      if (d[1]) m_udf[i] = 0;
    end
    if (ovf_set) m_ovf[i] = 1;
    if (udf_set) m_udf[i] = 1;
    if (wr && a == 8'h00) m_tdr[i] = d;
    if (wr && a == 8'h01) begin
      m_en[i]  = d[4];
      m_dn[i]  = d[5];
      m_cks[i] = d[1:0];
    end
  endtask

  // Reference model advances on every clock edge from the bench's own stimulus.
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < 2; i++) begin
        m_tdr[i] = 0; m_tcnt[i] = 0; m_en[i] = 0; m_dn[i] = 0;
        m_cks[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_k[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Monitor: checks handshake timing every cycle, pops the scoreboard on pready.
  always @(negedge pclk) begin
    if (!preset) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("inst%0d pready", i), int'(pready[i]), int'(exp_rdy[i]));
        if (exp_rdy[i]) begin
          mon_n = (i == 0) ? sb0.size() : sb1.size();
          checkOutput($sformatf("inst%0d scoreboard depth", i), mon_n, 1);
          if (mon_n > 0) begin
            mon_e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            checkOutput($sformatf("inst%0d prdata addr 0x%0h", i, mon_e[16:9]),
                        int'(prdata[i]), int'(mon_e[7:0]));
            checkOutput($sformatf("inst%0d pslverr addr 0x%0h", i, mon_e[16:9]),
                        int'(pslverr[i]), int'(mon_e[8]));
          end
        end else begin
          checkOutput($sformatf("inst%0d idle prdata", i), int'(prdata[i]), 0);
          checkOutput($sformatf("inst%0d idle pslverr", i), int'(pslverr[i]), 0);
        end
        checkOutput($sformatf("inst%0d irq_ovf", i), int'(irq_ovf[i]), m_ovf[i]);
        checkOutput($sformatf("inst%0d irq_udf", i), int'(irq_udf[i]), m_udf[i]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // One APB transfer; abort_at >= 0 drops psel at that access cycle.
  task automatic applyStimulus(input int i, input bit wr, input logic [7:0] a,
                               input logic [7:0] d, input int abort_at);
    logic [16:0] e;
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr;
    paddr[i] = a; pwdata[i] = d; exp_rdy[i] = 1'b0;
    idle(1);
    for (int n = 0; n <= wait_of[i]; n++) begin
      if (n == abort_at) begin
        psel[i] = 1'b0; penable[i] = 1'b0;
        idle(1);
        return;
      end
      penable[i] = 1'b1;
      exp_rdy[i] = (n == wait_of[i]);
      if (exp_rdy[i]) begin
        e = {a, (a > 8'h03), (wr || a > 8'h03) ? 8'h00 : model_read(i, a)};
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
      end
      idle(1);
    end
    psel[i] = 1'b0; penable[i] = 1'b0; exp_rdy[i] = 1'b0;
  endtask

  task automatic wr_reg(input int i, input logic [7:0] a, input logic [7:0] d);
    applyStimulus(i, 1'b1, a, d, -1);
  endtask

  task automatic rd_reg(input int i, input logic [7:0] a);
    applyStimulus(i, 1'b0, a, 8'h00, -1);
  endtask

  task automatic run_plan(input int i);
    for (int a = 0; a < 4; a++) rd_reg(i, 8'(a));
    wr_reg(i, 8'h00, 8'hA5);
    rd_reg(i, 8'h00);
    // Up count to overflow, then down count to underflow.
    wr_reg(i, 8'h01, 8'h10);
    idle(511);
    rd_reg(i, 8'h02);
    wr_reg(i, 8'h01, 8'h30);
    idle(1022);
    rd_reg(i, 8'h02);
    // Write-1-to-clear with the counter stopped.
    wr_reg(i, 8'h01, 8'h00);
    wr_reg(i, 8'h02, 8'h01);
    rd_reg(i, 8'h02);
    wr_reg(i, 8'h02, 8'h02);
    rd_reg(i, 8'h02);
    // Overflow lands on the same edge as a W1C of OVF.
    wr_reg(i, 8'h00, 8'hFF);
    wr_reg(i, 8'h01, 8'h92);
    idle(6 - wait_of[i]);
    wr_reg(i, 8'h02, 8'h01);
    rd_reg(i, 8'h02);
    // LOAD with prescale by 4.
    wr_reg(i, 8'h01, 8'h00);
    wr_reg(i, 8'h02, 8'h03);
    wr_reg(i, 8'h00, 8'hFE);
    wr_reg(i, 8'h01, 8'h91);
    rd_reg(i, 8'h03);
    rd_reg(i, 8'h01);
    idle(12);
    rd_reg(i, 8'h02);
    wr_reg(i, 8'h01, 8'h00);
    wr_reg(i, 8'h02, 8'h03);
    // Aborted write must leave TDR untouched.
    if (wait_of[i] > 0) begin
      applyStimulus(i, 1'b1, 8'h00, 8'h3C, 1);
      rd_reg(i, 8'h00);
    end
    // Unmapped address and read-only TCNT.
    wr_reg(i, 8'h07, 8'h55);
    rd_reg(i, 8'h07);
    wr_reg(i, 8'h03, 8'h77);
    for (int a = 0; a < 4; a++) rd_reg(i, 8'(a));
  endtask

  initial begin
    wait_of[0] = W0;
    wait_of[1] = W1;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 8'h00; pwdata[i] = 8'h00; exp_rdy[i] = 1'b0;
    end
    preset = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("inst%0d reset prdata", i), int'(prdata[i]), 0);
      checkOutput($sformatf("inst%0d reset pready", i), int'(pready[i]), 0);
    end
    idle(3);
    preset = 1'b0;
    $display("[TB] directed sequence, WAIT_CYCLES=%0d", W0);
    run_plan(0);
    $display("[TB] directed sequence, WAIT_CYCLES=%0d", W1);
    run_plan(1);
    $display("[TB] random transfers");
    repeat (80) begin
      int          i;
      logic [7:0]  a;
      i = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      applyStimulus(i, 1'($urandom), a, 8'($urandom), -1);
      idle(int'($urandom_range(0, 3)));
    end
    $display("[TB] asynchronous reset mid-count");
    for (int i = 0; i < 2; i++) wr_reg(i, 8'h01, 8'h10);
    idle(600);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("inst%0d pre-reset irq_ovf", i), int'(irq_ovf[i]), 1);
    #2;
    preset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("inst%0d async prdata", i), int'(prdata[i]), 0);
      checkOutput($sformatf("inst%0d async pready", i), int'(pready[i]), 0);
      checkOutput($sformatf("inst%0d async pslverr", i), int'(pslverr[i]), 0);
      checkOutput($sformatf("inst%0d async irq_ovf", i), int'(irq_ovf[i]), 0);
      checkOutput($sformatf("inst%0d async irq_udf", i), int'(irq_udf[i]), 0);
    end
    idle(2);
    preset = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 4; a++) rd_reg(i, 8'(a));
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
